// File: rtl/render_fxp_pkg.sv
// Shared fixed-point rendering definitions: element format defaults,
// matrix dimension, job state encoding and counter field layout.
package render_fxp_pkg;

    // Q8.8 element format by default: 1.0 = 16'h0100.
    localparam int WI_DEF = 8;
    localparam int WF_DEF = 8;

    // Matrices are MAT_N x MAT_N, stored row-major.
    localparam int MAT_N  = 4;
    localparam int N_ELEM = MAT_N * MAT_N;

    // The job counter is {r[1:0], c[1:0], k[1:0]}: element index i = {r, c}
    // occupies the upper four bits and the dot-product term k the lower two.
    localparam int K_W   = 2;
    localparam int I_W   = 4;
    localparam int CNT_W = I_W + K_W;

    localparam logic [K_W-1:0]   K_FIRST  = 2'd0;
    localparam logic [K_W-1:0]   K_LAST   = 2'd3;
    localparam logic [CNT_W-1:0] CNT_LAST = 6'd63;

    // Job state: IDLE waits for start, MAC runs the 64 multiply-accumulate
    // cycles, DONE is the single-cycle completion pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_mac_rs.sv
// Signed fixed-point multiply-accumulate with round-half-up and saturation.
// The accumulator is two bits wider than a full product so four terms can
// never wrap. The output reflects acc+p (or p alone on the first term) in
// the current cycle, so the last term's result is available combinationally.
module fxp_mac_rs
    import render_fxp_pkg::*;
#(
    parameter int WI = WI_DEF,
    parameter int WF = WF_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WI+WF-1:0]     a,
    input  logic [WI+WF-1:0]     b,
    output logic [WI+WF-1:0]     res,
    output logic                 ovf
);

    localparam int W  = WI + WF;
    localparam int AW = 2 * W + 2;

    logic signed [W-1:0]   a_s;
    logic signed [W-1:0]   b_s;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0]  prod_x;
    logic signed [AW-1:0]  acc_q;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  rnd;
    logic signed [AW-1:0]  shifted;
    logic [AW-W:0]         hi_bits;

    assign a_s = $signed(a);
    assign b_s = $signed(b);

    // Full-precision product, sign-extended into the accumulator width, then
    // either started fresh (first term) or added to the running sum.
    always_comb begin
        prod    = a_s * b_s;
        prod_x  = {{2{prod[2*W-1]}}, prod};
        sum     = clr ? prod_x : (acc_q + prod_x);
        rnd     = sum + $signed({{(AW-WF){1'b0}}, 1'b1, {(WF-1){1'b0}}});
        shifted = rnd >>> WF;
        hi_bits = shifted[AW-1:W-1];
        ovf     = !((&hi_bits) || (~|hi_bits));
        if (ovf) begin
            res = shifted[AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            res = shifted[W-1:0];
        end
    end

    // Running sum register; only advances while the multiplier is active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= sum;
        end
    end

endmodule

// File: rtl/mvp_mat4_mul.sv
// 4x4 fixed-point matrix multiplier, mat_out = mat_a * mat_b, using one
// time-shared MAC. A job snapshots both operands on start, spends 64 cycles
// in MAC (16 elements x 4 terms), then pulses done for one cycle.
//
// Handshake: start is a one-cycle request honoured only in IDLE; busy is high
// for exactly the 64 MAC cycles; done is a one-cycle pulse in the cycle after
// the last MAC and marks mat_out and overflow as coherent. A start while busy
// or done is dropped, never queued.
module mvp_mat4_mul
    import render_fxp_pkg::*;
#(
    parameter int WI = WI_DEF,
    parameter int WF = WF_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [15:0][WI+WF-1:0]      mat_a,
    input  logic [15:0][WI+WF-1:0]      mat_b,
    output logic                        busy,
    output logic                        done,
    output logic [15:0][WI+WF-1:0]      mat_out,
    output logic                        overflow
);

    localparam int W = WI + WF;

    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [15:0][W-1:0]     snap_a;
    logic [15:0][W-1:0]     snap_b;

    logic [1:0]             row;
    logic [1:0]             col;
    logic [K_W-1:0]         term;
    logic [I_W-1:0]         elem;
    logic [W-1:0]           op_a;
    logic [W-1:0]           op_b;
    logic [W-1:0]           mac_res;
    logic                   mac_ovf;
    logic                   mac_en;
    logic                   accept;

    assign row    = cnt_q[5:4];
    assign col    = cnt_q[3:2];
    assign term   = cnt_q[1:0];
    assign elem   = cnt_q[5:2];

    // Row-major operands: A(r,k) at r*4+k, B(k,c) at k*4+c.
    assign op_a   = snap_a[{row, term}];
    assign op_b   = snap_b[{term, col}];

    assign mac_en = (state_q == MAC);
    assign accept = (state_q == IDLE) && start;

    fxp_mac_rs #(
        .WI (WI),
        .WF (WF)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (mac_en),
        .clr   (term == K_FIRST),
        .a     (op_a),
        .b     (op_b),
        .res   (mac_res),
        .ovf   (mac_ovf)
    );

    // Next-state logic and status outputs decoded from the current state.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset takes priority over a simultaneous start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand snapshot, job counter, result write-back and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            snap_a   <= '0;
            snap_b   <= '0;
            mat_out  <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            cnt_q    <= '0;
            snap_a   <= mat_a;
            snap_b   <= mat_b;
            overflow <= 1'b0;
        end else if (mac_en) begin
            cnt_q <= cnt_q + 1'b1;
            if (term == K_LAST) begin
                mat_out[elem] <= mac_res;
                overflow      <= overflow | mac_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mvp_mat4_mul.sv
// Self-checking bench for mvp_mat4_mul: directed and random jobs, expected
// results from an integer reference model pushed into a queue and checked by
// an independent monitor on every done pulse.
module tb_mvp_mat4_mul;

    localparam int W     = 16;
    localparam int WF    = 8;
    localparam int EXP_W = 16 * W + 1;

    typedef logic [15:0][W-1:0] mat_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    mat_t       mat_a;
    mat_t       mat_b;
    logic       busy;
    logic       done;
    mat_t       mat_out;
    logic       overflow;

    logic [EXP_W-1:0] exp_q[$];
    int checks;
    int errors;

    mvp_mat4_mul dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .busy     (busy),
        .done     (done),
        .mat_out  (mat_out),
        .overflow (overflow)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer dot products, round half up, saturate.
    function automatic logic [EXP_W-1:0] ref_mul(input mat_t a, input mat_t b);
        longint s;
        longint q;
        logic   ov;
        mat_t   m;
        ov = 1'b0;
        m  = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++) begin
                    s += longint'($signed(a[r*4+k])) * longint'($signed(b[k*4+c]));
                end
                q = (s + (longint'(1) << (WF - 1))) >>> WF;
                if (q > 32767) begin
                    q  = 32767;
                    ov = 1'b1;
                end else if (q < -32768) begin
                    q  = -32768;
                    ov = 1'b1;
                end
                m[r*4+c] = q[15:0];
            end
        end
        return {ov, m};
    endfunction

    function automatic mat_t identity();
        mat_t m;
        m = '0;
        for (int d = 0; d < 4; d++) m[d*5] = 16'h0100;
        return m;
    endfunction

    function automatic mat_t view_mat();
        mat_t m;
        m     = identity();
        m[3]  = 16'hFD80;
        m[7]  = 16'h0100;
        m[11] = 16'h0000;
        m[15] = 16'h0100;
        return m;
    endfunction

    function automatic mat_t rand_mat(input int span);
        mat_t m;
        int   v;
        for (int e = 0; e < 16; e++) begin
            v    = int'($urandom_range(0, 2 * span)) - span;
            m[e] = v[15:0];
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending job");
            end else begin
                logic [EXP_W-1:0] e;
                mat_t             em;
                e  = exp_q.pop_front();
                em = e[16*W-1:0];
                for (int k = 0; k < 16; k++) begin
                    checks++;
                    if (mat_out[k] !== em[k]) begin
                        errors++;
                        $display("FAIL mat_out[%0d]: got %h expected %h", k, mat_out[k], em[k]);
                    end
                end
                checks++;
                if (overflow !== e[EXP_W-1]) begin
                    errors++;
                    $display("FAIL overflow_at_done: got %b expected %b", overflow, e[EXP_W-1]);
                end
            end
        end
    end

    // Driver: one job, timing and hold checks; optional mid-job disturbance.
    task automatic run_job(input mat_t a, input mat_t b, input bit disturb);
        logic [EXP_W-1:0] e;
        mat_t             em;
        bit               busy_ok;
        int               done_cyc;
        int               n_done;
        e  = ref_mul(a, b);
        em = e[16*W-1:0];
        exp_q.push_back(e);
        mat_a = a;
        mat_b = b;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        busy_ok  = 1'b1;
        done_cyc = -1;
        n_done   = 0;
        for (int n = 1; n <= 68; n++) begin
            if (n <= 64 && busy !== 1'b1) busy_ok = 1'b0;
            if (n > 64 && busy !== 1'b0) busy_ok = 1'b0;
            if (done === 1'b1) begin
                n_done++;
                done_cyc = n;
            end
            if (disturb) begin
                if (n == 5) mat_a = rand_mat(30000);
                if (n == 7) mat_b = rand_mat(30000);
                start = (n == 10 || n == 64);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check("done_cycle", done_cyc, 65);
        check("done_count", n_done, 1);
        check("busy_window", {31'd0, busy_ok}, 32'd1);
        check("mat_out_hold", {31'd0, mat_out === em}, 32'd1);
    endtask

    task automatic reset_mid_job();
        int n_done;
        mat_a = rand_mat(600);
        mat_b = rand_mat(600);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n < 30; n++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_overflow", {31'd0, overflow}, 32'd0);
        check("rst_mid_mat_out_zero", {31'd0, mat_out === '0}, 32'd1);
        n_done = 0;
        for (int n = 0; n < 70; n++) begin
            if (done === 1'b1) n_done++;
            @(posedge clk); #1;
        end
        check("rst_mid_no_done", n_done, 0);
    endtask

    initial begin
        mat_t a;
        mat_t b;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b1;
        mat_a  = identity();
        mat_b  = view_mat();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_overflow", {31'd0, overflow}, 32'd0);
        check("reset_mat_out", {31'd0, mat_out === '0}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("start_during_reset_dropped", {31'd0, busy}, 32'd0);

        // Identity times view reproduces the view matrix.
        run_job(identity(), view_mat(), 1'b0);
        check("ident_m3", mat_out[3], 16'hFD80);
        check("ident_overflow", {31'd0, overflow}, 32'd0);

        // Scale by 2 in xyz.
        a = '0;
        a[0] = 16'h0200; a[5] = 16'h0200; a[10] = 16'h0200; a[15] = 16'h0100;
        run_job(a, view_mat(), 1'b0);
        check("scale_m0", mat_out[0], 16'h0200);
        check("scale_m3", mat_out[3], 16'hFB00);
        check("scale_m7", mat_out[7], 16'h0200);
        check("scale_m15", mat_out[15], 16'h0100);

        // Positive saturation, then overflow clears on the next job.
        a = '0; b = '0;
        a[0] = 16'h7F00; b[0] = 16'h7F00;
        run_job(a, b, 1'b0);
        check("sat_m0", mat_out[0], 16'h7FFF);
        check("sat_overflow", {31'd0, overflow}, 32'd1);
        run_job(identity(), identity(), 1'b0);
        check("sat_cleared", {31'd0, overflow}, 32'd0);

        // Negative saturation.
        a = '0; b = '0;
        a[0] = 16'h8000; b[0] = 16'h7F00;
        run_job(a, b, 1'b0);
        check("negsat_m0", mat_out[0], 16'h8000);

        // Rounding half up.
        a = '0; b = '0;
        a[0] = 16'h0001; b[0] = 16'h0080;
        run_job(a, b, 1'b0);
        check("round_pos_half", mat_out[0], 16'h0001);
        a[0] = 16'hFFFF;
        run_job(a, b, 1'b0);
        check("round_neg_half", mat_out[0], 16'h0000);

        // Restart attempts and operand changes during a job.
        run_job(rand_mat(1024), rand_mat(1024), 1'b1);

        // Abort by reset, then a fresh job.
        reset_mid_job();
        run_job(view_mat(), rand_mat(2048), 1'b0);

        // Random jobs: modest range, then full range (saturation likely).
        for (int j = 0; j < 4; j++) run_job(rand_mat(1024), rand_mat(1024), j[0]);
        for (int j = 0; j < 2; j++) run_job(rand_mat(32767), rand_mat(32767), 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mvp_mat4_mul.md
Name: mvp_mat4_mul

Overview:
- Sequential 4x4 fixed-point matrix multiplier that forms out = mat_a * mat_b.
- Sits directly downstream of the view-matrix generator: mat_b is the view matrix, and mat_a is the projection (or projection*model) matrix.
- Produces the combined MVP matrix consumed by the vertex transform stage.
- Uses a single time-shared multiply-accumulate unit so that it fits the FPGA DSP budget.

Parameters:
- WI, 8, integer bits of every matrix element (signed two's complement, sign included)
- WF, 8, fractional bits of every matrix element
- Element width W = WI+WF (default 16, Q8.8); 1.0 = 16'h0100.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  synchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- mat_a  input  [15:0][W-1:0]  left operand; row-major, element (r,c) at index r*4+c
- mat_b  input  [15:0][W-1:0]  right operand (view matrix); same layout
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when mat_out is valid
- mat_out  output  [15:0][W-1:0]  result, row-major; held stable between jobs
- overflow  output  1  sticky per job; set if any element saturated

Behaviour:
- Reset is synchronous and active-low: all state is cleared when rst_n is low at a rising clk edge.
- Reset values: state=IDLE, busy=0, done=0, overflow=0, mat_out all zero, internal counters 0.
- States and transitions:
  - IDLE -> MAC when start=1. On that edge, mat_a and mat_b are snapshotted into internal registers and overflow is cleared.
  - MAC runs 64 cycles. Element index i counts 0..15 (r=i/4, c=i%4); term k counts 0..3 inside each element.
  - Each MAC cycle: p = A[r*4+k] * B[k*4+c], full 2W-bit signed product. acc = (k==0 ? p : acc+p). The accumulator is 2W+2 bits, so accumulation never wraps.
  - On the edge ending k==3: round and saturate (acc+p), write it to mat_out[i], then advance i. After i==15 the state moves to DONE.
  - DONE lasts 1 cycle: done=1, busy=0; then IDLE.
- Timing and handshake:
  - If start is sampled on edge 0, busy=1 for cycles 1..64 and done=1 in cycle 65.
  - start in any non-IDLE state is ignored. No queuing, no restart.
  - Input changes after acceptance have no effect on the running job (snapshot).
- mat_out update rules:
  - Elements update progressively during MAC; they are guaranteed coherent only from done onward.
  - After done, mat_out holds until the next job writes element 0.
- Rounding and saturation:
  - Add 2^(WF-1) to the 2WF-fraction sum, then arithmetic shift right by WF. This is round-half-up toward +inf.
  - Saturate to [-2^(W-1), 2^(W-1)-1]; saturation sets overflow, which stays set until the next accepted start.
- Reset mid-operation: abort immediately and return to the reset values. No done pulse is produced for the aborted job.
- A start in the same cycle as rst_n=0 is discarded.

Decomposition:
- Package render_fxp_pkg holds:
  - WI/WF defaults and MAT_N=4
  - the state enum {IDLE, MAC, DONE}
  - the element-index helper constants
- One sub-module, fxp_mac_rs, computes:
  - the signed multiply
  - the wide accumulate with clear-on-k0
  - combinational round/saturate with an overflow flag
- The top level owns the FSM, counters, snapshot registers and mat_out.

Test Plan:
- Identity case: mat_a = identity (diagonal 0x0100), mat_b = view with col3 = {0xFD80, 0x0100, 0x0000, 0x0100} (tx=-2.5, ty=1.0, tz=0.0, w=1.0) -> mat_out == mat_b bit-exact, done exactly 65 cycles after start, busy high cycles 1..64, overflow=0.
- Scale case: mat_a = diag(2.0, 2.0, 2.0, 1.0) = 0x0200 entries, mat_b same translation -> mat_out[3]=0xFB00 (-5.0), mat_out[7]=0x0200, mat_out[0]=0x0200, mat_out[15]=0x0100.
- Saturation: mat_a[0]=mat_b[0]=0x7F00, others 0 -> mat_out[0]=0x7FFF and overflow=1. A next job with identity inputs clears overflow to 0.
- Rounding:
  - mat_a[0]=0x0001, mat_b[0]=0x0080 -> mat_out[0]=0x0001.
  - mat_a[0]=0xFFFF, mat_b[0]=0x0080 -> mat_out[0]=0x0000.
- Handshake: pulse start again at cycles 10 and 64 while busy, and change mat_a mid-job -> single done at cycle 65, and the result matches the original snapshot.
- Reset mid-operation: assert rst_n=0 at cycle 30 -> next cycle busy=0, done=0, mat_out=0, overflow=0, and no done pulse follows. A fresh start then completes normally in 65 cycles.
